// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the configurable serial sequence detector.
package seq_det_pkg;

  localparam int unsigned DEF_MAXLEN = 8;
  localparam int unsigned DEF_CNTW   = 8;
  localparam int unsigned LENW       = $clog2(DEF_MAXLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_det_ctrl_core.sv
// Match datapath: bit history, bits-seen counter and length-masked comparator.
module seq_match_core #(
  parameter int unsigned MAXLEN = 8,
  parameter int unsigned LENW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              x,
  input  logic [LENW-1:0]   len,
  input  logic [MAXLEN-1:0] pattern,
  input  logic              overlap,
  output logic              hit
);

  logic [MAXLEN-1:0] hist_q, hist_d, hist_shift, mask;
  logic [LENW-1:0]   bits_q, bits_d, bits_inc;

  // hit is judged on the post-shift history so the controller can register
  // the match pulse at the same edge that accepts the completing bit.
  always_comb begin
    hist_shift = {hist_q[MAXLEN-2:0], x};
    bits_inc   = (bits_q >= len) ? bits_q : bits_q + 1'b1;
    mask       = '0;
    for (int unsigned i = 0; i < MAXLEN; i++) begin
      mask[i] = (LENW'(i) < len);
    end
    hit = shift_en && (bits_inc >= len) && (((hist_shift ^ pattern) & mask) == '0);

    hist_d = hist_q;
    bits_d = bits_q;
    if (clr) begin
      hist_d = '0;
      bits_d = '0;
    end else if (shift_en) begin
      hist_d = hist_shift;
      bits_d = (hit && !overlap) ? '0 : bits_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      bits_q <= '0;
    end else begin
      hist_q <= hist_d;
      bits_q <= bits_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Sequencing controller: config latch, IDLE/RUN/DONE FSM, match counting.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned MAXLEN = DEF_MAXLEN,
  parameter int unsigned CNTW   = DEF_CNTW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [MAXLEN-1:0]            cfg_pattern,
  input  logic [$clog2(MAXLEN+1)-1:0]  cfg_len,
  input  logic                         cfg_overlap,
  input  logic [CNTW-1:0]              cfg_target,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         x_valid,
  input  logic                         x,
  output logic                         match,
  output logic [CNTW-1:0]              match_cnt,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err
);

  localparam int unsigned LEN_W = $clog2(MAXLEN + 1);

  state_e              state_q, state_d;
  logic [MAXLEN-1:0]   pattern_q, pattern_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                overlap_q, overlap_d;
  logic [CNTW-1:0]     target_q, target_d;
  logic [CNTW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic                match_q, match_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cfg_ok;
  logic                core_clr;
  logic                shift_en;
  logic                hit;

  seq_match_core #(
    .MAXLEN (MAXLEN),
    .LENW   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (core_clr),
    .shift_en (shift_en),
    .x        (x),
    .len      (len_q),
    .pattern  (pattern_q),
    .overlap  (overlap_q),
    .hit      (hit)
  );

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    match_d   = 1'b0;
    err_d     = 1'b0;
    core_clr  = 1'b0;
    shift_en  = 1'b0;
    cfg_ok    = (len_q != '0) && (32'(len_q) <= MAXLEN);
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    unique case (state_q)
      IDLE, DONE: begin
        // start is judged against the config latched before this edge
        if (cfg_we) begin
          pattern_d = cfg_pattern;
          len_d     = cfg_len;
          overlap_d = cfg_overlap;
          target_d  = cfg_target;
        end
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          if (!cfg_ok) begin
            err_d = 1'b1;
          end else begin
            core_clr = 1'b1;
            cnt_d    = '0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (x_valid) begin
          shift_en = 1'b1;
          if (hit) begin
            match_d = 1'b1;
            cnt_d   = cnt_inc;
            if ((target_q != '0) && (cnt_inc == target_q)) begin
              state_d = DONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      target_q  <= '0;
      cnt_q     <= '0;
      match_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed vector bench for seq_det_ctrl (MAXLEN = 8, CNTW = 8).
module tb_seq_det_ctrl;

  localparam int unsigned MAXLEN = 8;
  localparam int unsigned CNTW   = 8;
  localparam int unsigned LW     = 4;

  logic              clk, rst;
  logic              cfg_we, cfg_overlap, start, abort, x_valid, x;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LW-1:0]     cfg_len;
  logic [CNTW-1:0]   cfg_target;
  logic              match, busy, done, cfg_err;
  logic [CNTW-1:0]   match_cnt;

  seq_det_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .x_valid     (x_valid),
    .x           (x),
    .match       (match),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ov;
    logic [7:0]  tgt;
    logic        st;
    logic        ab;
    logic        xv;
    logic        xb;
    logic        e_match;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %0h expected %0h", name, vec_no, act, exp);
    end
  endtask

  task automatic chk_all(input logic em, input logic eb, input logic ed,
                         input logic ee, input logic [7:0] ec);
    chk("match", 32'(match), 32'(em));
    chk("busy", 32'(busy), 32'(eb));
    chk("done", 32'(done), 32'(ed));
    chk("cfg_err", 32'(cfg_err), 32'(ee));
    chk("match_cnt", 32'(match_cnt), 32'(ec));
  endtask

  task automatic add(input logic we, input logic [7:0] pat, input logic [3:0] len,
                     input logic ov, input logic [7:0] tgt, input logic st, input logic ab,
                     input logic xv, input logic xb, input logic em, input logic eb,
                     input logic ed, input logic ee, input logic [7:0] ec);
    vec_t v;
    v.we = we; v.pat = pat; v.len = len; v.ov = ov; v.tgt = tgt;
    v.st = st; v.ab = ab; v.xv = xv; v.xb = xb;
    v.e_match = em; v.e_busy = eb; v.e_done = ed; v.e_err = ee; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic add_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                         input logic [7:0] tgt, input logic eb, input logic ed,
                         input logic [7:0] ec);
    add(1'b1, pat, len, ov, tgt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, eb, ed, 1'b0, ec);
  endtask

  task automatic add_start(input logic eb, input logic ee, input logic [7:0] ec);
    add(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, eb, 1'b0, ee, ec);
  endtask

  task automatic add_bit(input logic xv, input logic xb, input logic em, input logic eb,
                         input logic ed, input logic [7:0] ec);
    add(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, xv, xb, em, eb, ed, 1'b0, ec);
  endtask

  task automatic add_abort(input logic [7:0] ec);
    add(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ec);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    cfg_we = v.we; cfg_pattern = v.pat; cfg_len = v.len; cfg_overlap = v.ov;
    cfg_target = v.tgt; start = v.st; abort = v.ab; x_valid = v.xv; x = v.xb;
    @(posedge clk);
    #1;
    chk_all(v.e_match, v.e_busy, v.e_done, v.e_err, v.e_cnt);
    vec_no++;
  endtask

  task automatic run_queue();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    cfg_target = '0; start = 0; abort = 0; x_valid = 0; x = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk) rst = 1'b0;

    // non-overlap, 10110 on stream 1,0,1,1,0,1,1,0
    add_cfg(8'b10110, 4'd5, 1'b0, 8'd0, 0, 0, 8'd0);
    add_start(1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(1, 0, 0, 1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(1, 0, 1, 1, 0, 8'd1);
    add_bit(1, 1, 0, 1, 0, 8'd1);
    add_bit(1, 1, 0, 1, 0, 8'd1);
    add_bit(1, 0, 0, 1, 0, 8'd1);
    add_abort(8'd1);
    // overlap, same stream
    add_cfg(8'b10110, 4'd5, 1'b1, 8'd0, 0, 0, 8'd1);
    add_start(1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(1, 0, 0, 1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(1, 0, 1, 1, 0, 8'd1);
    add_bit(1, 1, 0, 1, 0, 8'd1);
    add_bit(1, 1, 0, 1, 0, 8'd1);
    add_bit(1, 0, 1, 1, 0, 8'd2);
    add_abort(8'd2);
    // target stop: 11, len 2, target 2
    add_cfg(8'b11, 4'd2, 1'b0, 8'd2, 0, 0, 8'd2);
    add_start(1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(1, 1, 1, 1, 0, 8'd1);
    add_bit(1, 1, 0, 1, 0, 8'd1);
    add_bit(1, 1, 1, 0, 1, 8'd2);
    add_bit(1, 1, 0, 0, 1, 8'd2);
    add_bit(1, 1, 0, 0, 1, 8'd2);
    // gapped 10110, reconfigured from DONE
    add_cfg(8'b10110, 4'd5, 1'b0, 8'd0, 0, 1, 8'd2);
    add_start(1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(0, 0, 0, 1, 0, 8'd0);
    add_bit(1, 0, 0, 1, 0, 8'd0);
    add_bit(0, 1, 0, 1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(0, 0, 0, 1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(0, 1, 0, 1, 0, 8'd0);
    add_bit(1, 0, 1, 1, 0, 8'd1);
    add_bit(0, 0, 0, 1, 0, 8'd1);
    add_abort(8'd1);
    // config errors: len 0, cfg_we+start together uses old len, len 9, then len 3
    add_cfg(8'h00, 4'd0, 1'b0, 8'd0, 0, 0, 8'd1);
    add(1'b1, 8'b101, 4'd3, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1, 8'd1);
    add_bit(0, 0, 0, 0, 0, 8'd1);
    add_cfg(8'h00, 4'd9, 1'b0, 8'd0, 0, 0, 8'd1);
    add_start(0, 1, 8'd1);
    add_bit(0, 0, 0, 0, 0, 8'd1);
    add_cfg(8'b101, 4'd3, 1'b0, 8'd0, 0, 0, 8'd1);
    add_start(1, 0, 8'd0);
    add_abort(8'd0);
    // abort after 3 bits of 10110 (bit in abort cycle dropped), then restart
    add_cfg(8'b10110, 4'd5, 1'b0, 8'd0, 0, 0, 8'd0);
    add_start(1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(1, 0, 0, 1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_abort(8'd0);
    add_bit(1, 1, 0, 0, 0, 8'd0);
    add_start(1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(1, 0, 0, 1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(1, 0, 1, 1, 0, 8'd1);
    add_abort(8'd1);
    // len 1, target 3, then abort from DONE
    add_cfg(8'b01, 4'd1, 1'b0, 8'd3, 0, 0, 8'd1);
    add_start(1, 0, 8'd0);
    add_bit(1, 1, 1, 1, 0, 8'd1);
    add_bit(1, 0, 0, 1, 0, 8'd1);
    add_bit(1, 1, 1, 1, 0, 8'd2);
    add_bit(0, 0, 0, 1, 0, 8'd2);
    add_bit(1, 1, 1, 0, 1, 8'd3);
    add_bit(1, 1, 0, 0, 1, 8'd3);
    add_abort(8'd3);
    run_queue();

    // reset mid-RUN discards everything, including config
    add_cfg(8'b10110, 4'd5, 1'b0, 8'd0, 0, 0, 8'd3);
    add_start(1, 0, 8'd0);
    add_bit(1, 1, 0, 1, 0, 8'd0);
    add_bit(1, 0, 0, 1, 0, 8'd0);
    run_queue();
    @(negedge clk);
    rst = 1'b1; x_valid = 1'b1; x = 1'b1;
    @(posedge clk);
    #1;
    chk_all(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0; x_valid = 1'b0;
    add_start(0, 1, 8'd0);
    run_queue();

    // free-run saturation: len 1 pattern 1, 300 ones
    add_cfg(8'b1, 4'd1, 1'b0, 8'd0, 0, 0, 8'd0);
    add_start(1, 0, 8'd0);
    run_queue();
    @(negedge clk);
    x_valid = 1'b1; x = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk_all(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    @(negedge clk);
    x_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
